// File: rtl/a_pipe_play_trce.sv
// Trace replay pipeline: buffers host-written {user-clock, signal} samples in a
// small FIFO and plays them back through a programmable 0..14 stage delay line
// so replayed stimulus lines up with the capture pipeline's latency.
module a_pipe_play_trce #(
    parameter int SIG_W     = 1,
    parameter int DEPTH     = 16,
    parameter int PRIME_LVL = 4
) (
    input  logic                     clk_ref,
    input  logic                     rst_n,
    input  logic [3:0]               nbr_pipe,
    input  logic                     wr_en_i,
    input  logic                     wr_clk_i,
    input  logic [SIG_W-1:0]         wr_sig_i,
    input  logic                     runverif_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     clk_user_o,
    output logic [SIG_W-1:0]         signal_o,
    output logic                     runpipe_o,
    output logic                     underrun_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = SIG_W + 1;   // {clk, sig}
    localparam int NS = 14;          // registered stages behind the insert point

    typedef enum logic [1:0] {IDLE, PRIME, PLAY, STOP} state_t;

    state_t           state_q, state_d;
    logic             run_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    last_q, last_d;
    logic [3:0]       dly_q, dly_d;
    logic             underrun_q, underrun_d, overflow_q, overflow_d;
    logic [EW:0]      stg_q [NS];
    logic [EW:0]      stg_d [NS];
    logic [EW:0]      taps [16];
    logic [EW:0]      ins;
    logic [EW:0]      out_q, out_d;

    logic run_rise, run_fall, wr_acc, pop, start_run, set_underrun;

    assign run_rise = ~run_q & runverif_i;
    assign run_fall = run_q & ~runverif_i;
    assign wr_acc   = wr_en_i & ~full_q;

    // State register and all pipeline/FIFO flops
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            last_q     <= '0;
            dly_q      <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            out_q      <= '0;
            for (int unsigned i = 0; i < NS; i++) stg_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= runverif_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            last_q     <= last_d;
            dly_q      <= dly_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
            for (int unsigned i = 0; i < NS; i++) stg_q[i] <= stg_d[i];
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk_ref) begin
        if (wr_acc) mem_q[wr_ptr_q] <= {wr_clk_i, wr_sig_i};
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (run_rise) state_d = PRIME;
            PRIME: begin
                if (run_fall)                              state_d = STOP;
                else if (level_q >= (AW+1)'(PRIME_LVL))    state_d = PLAY;
            end
            PLAY:  if (run_fall) state_d = STOP;
            STOP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop request, run start and underrun detection
    always_comb begin
        pop          = 1'b0;
        start_run    = 1'b0;
        set_underrun = 1'b0;
        unique case (state_q)
            IDLE: start_run = run_rise;
            PLAY: begin
                if (!run_fall) begin
                    pop          = (level_q != '0);
                    set_underrun = (level_q == '0);
                end
            end
            default: ;
        endcase
    end

    // FIFO pointers, level, flags and delay-select latch
    always_comb begin
        wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        unique case ({wr_acc, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: ;
        endcase
        full_d     = (level_d == (AW+1)'(DEPTH));
        last_d     = pop ? mem_q[rd_ptr_q] : last_q;
        dly_d      = start_run ? nbr_pipe : dly_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        if (start_run) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (set_underrun)          underrun_d = 1'b1;
        if (wr_en_i && full_q)     overflow_d = 1'b1;
    end

    // Delay line: the insert point acts as stage 0 feeding the output register
    // directly, so one output flop plus 14 stages gives t+1+dly latency.
    // Tap 15 is constant zero, which disables the outputs when selected.
    always_comb begin
        ins = pop ? {1'b1, mem_q[rd_ptr_q]} : {1'b0, last_q};
        stg_d[0] = ins;
        for (int unsigned i = 1; i < NS; i++) stg_d[i] = stg_q[i-1];
        taps[0] = ins;
        for (int unsigned i = 1; i < 15; i++) taps[i] = stg_q[i-1];
        taps[15] = '0;
        out_d = taps[dly_q];
    end

    assign full_o     = full_q;
    assign level_o    = level_q;
    assign runpipe_o  = out_q[EW];
    assign clk_user_o = out_q[EW-1];
    assign signal_o   = out_q[SIG_W-1:0];
    assign underrun_o = underrun_q;
    assign overflow_o = overflow_q;

endmodule
